// File: rtl/spi_slave.sv
// SPI responder: oversamples SCK/CS_n/MOSI, shifts bytes MSb first, DV/Ready byte handshake.
// Latency: o_RX_DV fires SYNC_STAGES+2 cycles after the clock edge that first sees the final sample edge.
// Backpressure: none on RX (one-cycle pulse); TX holding register refuses i_TX_DV while o_TX_Ready=0.
// Optional error outputs o_TX_Underrun/o_RX_Overrun are built when SPI_SLAVE_ERR_EN is defined.
module spi_slave #(
    parameter int SPI_MODE    = 0,
    parameter int SYNC_STAGES = 2    // >= 2
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_TX_DV,
    output logic       o_TX_Ready,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_Busy,
    input  logic       i_SPI_Clk,
    input  logic       i_SPI_CS_n,
    input  logic       i_SPI_MOSI,
    output logic       o_SPI_MISO,
`ifdef SPI_SLAVE_ERR_EN
    output logic       o_TX_Underrun,
    output logic       o_RX_Overrun,
`endif
    output logic       o_SPI_MISO_OE
);

    localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
    localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sck_prev;
    logic                   cs_prev;

    logic                   lead;
    logic                   trail;
    logic                   cs_fall;
    logic                   cs_rise;

    state_t                 state;
    state_t                 state_nxt;
    logic                   entry;
    logic                   cs_end;
    logic                   sample;
    logic                   drive;

    logic [2:0]             bit_cnt;
    logic [7:0]             rx_shift;
    logic [7:0]             tx_shift;
    logic                   miso;
    logic                   hold_vld;
    logic [7:0]             hold_dat;
    logic                   byte_end;
    logic                   load;
    logic [7:0]             load_val;
    logic                   accept;

    // Completed bytes travel through two stages so RX_DV lands at a fixed offset.
    logic [7:0]             cap_dat;
    logic                   cap_vld;
    logic                   cap_vld2;
    logic                   rx_dv;
    logic [7:0]             rx_byte;

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Pin synchronizers plus previous-value registers for edge detection.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            sck_sync  <= {SYNC_STAGES{CPOL}};
            cs_sync   <= {SYNC_STAGES{1'b1}};
            mosi_sync <= '0;
            sck_prev  <= CPOL;
            cs_prev   <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], i_SPI_Clk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_SPI_CS_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_SPI_MOSI};
            sck_prev  <= sck_s;
            cs_prev   <= cs_s;
        end
    end

    // SCK edges only count while the synchronized chip select is low.
    assign lead    = (sck_prev == CPOL) && (sck_s != CPOL) && !cs_s;
    assign trail   = (sck_prev != CPOL) && (sck_s == CPOL) && !cs_s;
    assign cs_fall = cs_prev && !cs_s;
    assign cs_rise = !cs_prev && cs_s;

    // State register.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle strobes for the datapath.
    always_comb begin
        state_nxt = state;
        entry     = 1'b0;
        cs_end    = 1'b0;
        sample    = 1'b0;
        drive     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_nxt = ST_ACTIVE;
                    entry     = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    state_nxt = ST_IDLE;
                    cs_end    = 1'b1;
                end else begin
                    sample = CPHA ? trail : lead;
                    drive  = CPHA ? lead : trail;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign byte_end = sample && (bit_cnt == 3'd0);
    assign load     = entry || byte_end;
    assign load_val = hold_vld ? hold_dat : 8'h00;
    assign accept   = i_TX_DV && !hold_vld;

    // Bit counter and receive shift register; a CS rise throws away partial data.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            bit_cnt  <= 3'd7;
            rx_shift <= 8'h00;
        end else if (entry || cs_end) begin
            bit_cnt  <= 3'd7;
            rx_shift <= 8'h00;
        end else if (sample) begin
            rx_shift[bit_cnt] <= mosi_s;
            bit_cnt           <= (bit_cnt == 3'd0) ? 3'd7 : bit_cnt - 3'd1;
        end
    end

    // Transmit shift register and MISO: first bit goes out right after CS fall,
    // the rest at each drive point, always indexing by the current bit counter.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            tx_shift <= 8'h00;
            miso     <= 1'b0;
        end else begin
            if (load) begin
                tx_shift <= load_val;
            end
            if (entry) begin
                miso <= load_val[7];
            end else if (drive) begin
                miso <= tx_shift[bit_cnt];
            end
        end
    end

    // Single-entry holding register; a reload in the same cycle as an accept
    // takes the old (empty) content and the new byte stays behind.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            hold_vld <= 1'b0;
            hold_dat <= 8'h00;
        end else if (accept) begin
            hold_vld <= 1'b1;
            hold_dat <= i_TX_Byte;
        end else if (load) begin
            hold_vld <= 1'b0;
        end
    end

    // Completed-byte pipeline towards the RX handshake.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            cap_dat  <= 8'h00;
            cap_vld  <= 1'b0;
            cap_vld2 <= 1'b0;
            rx_dv    <= 1'b0;
            rx_byte  <= 8'h00;
        end else begin
            cap_vld  <= byte_end;
            if (byte_end) begin
                cap_dat <= {rx_shift[7:1], mosi_s};
            end
            cap_vld2 <= cap_vld;
            rx_dv    <= cap_vld2;
            if (cap_vld2) begin
                rx_byte <= cap_dat;
            end
        end
    end

`ifdef SPI_SLAVE_ERR_EN
    logic [3:0] smp_since;
    logic       cap_ovr;
    logic       cap_ovr2;
    logic       tx_und;
    logic       rx_ovr;

    // Underrun on an empty reload; overrun when a byte completes within
    // 8 sample points of the previous completed byte.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            smp_since <= 4'hF;
            cap_ovr   <= 1'b0;
            cap_ovr2  <= 1'b0;
            tx_und    <= 1'b0;
            rx_ovr    <= 1'b0;
        end else begin
            tx_und  <= byte_end && !hold_vld;
            cap_ovr <= byte_end && (smp_since < 4'd8);
            if (byte_end) begin
                smp_since <= 4'd0;
            end else if (sample && (smp_since != 4'hF)) begin
                smp_since <= smp_since + 4'd1;
            end
            cap_ovr2 <= cap_ovr;
            rx_ovr   <= cap_ovr2;
        end
    end

    assign o_TX_Underrun = tx_und;
    assign o_RX_Overrun  = rx_ovr;
`endif

    assign o_TX_Ready    = !hold_vld;
    assign o_RX_DV       = rx_dv;
    assign o_RX_Byte     = rx_byte;
    assign o_Busy        = !cs_s;
    assign o_SPI_MISO    = miso;
    assign o_SPI_MISO_OE = !cs_s;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one instance per SPI mode, bench acts as the SPI master at SCK = clk/8.
// Expected MISO/RX bytes come from a byte-level model of the holding register and transfer list.
// Latency of every o_RX_DV is checked against the final sampling SCK edge.
module tb_spi_slave;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_byte = 8'h00;
    logic       tx_dv   [4];
    logic       sck     [4];
    logic       cs_n    [4];
    logic       mosi    [4];
    logic       tx_rdy  [4];
    logic       rx_dv   [4];
    logic [7:0] rx_byte [4];
    logic       busy    [4];
    logic       miso    [4];
    logic       oe      [4];
`ifdef SPI_SLAVE_ERR_EN
    logic       und     [4];
    logic       ovr     [4];
    int         und_cnt [4] = '{0, 0, 0, 0};
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int         m;
        int         c;
        logic [7:0] dat;
    } rx_ev_t;

    rx_ev_t rxq[$];
    int     smp_q[$];

    // Transfer description used by xfer()
    int         tb_n;
    bit         tb_pre_en;
    logic [7:0] tb_pre;
    logic [7:0] tb_b     [3];
    bit         tb_rf_en [3];
    logic [7:0] tb_rf    [3];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave #(.SPI_MODE(g), .SYNC_STAGES(SYNC)) u_dut (
            .i_Clk         (clk),
            .i_Rst         (rst),
            .i_TX_Byte     (tx_byte),
            .i_TX_DV       (tx_dv[g]),
            .o_TX_Ready    (tx_rdy[g]),
            .o_RX_DV       (rx_dv[g]),
            .o_RX_Byte     (rx_byte[g]),
            .o_Busy        (busy[g]),
            .i_SPI_Clk     (sck[g]),
            .i_SPI_CS_n    (cs_n[g]),
            .i_SPI_MOSI    (mosi[g]),
            .o_SPI_MISO    (miso[g]),
`ifdef SPI_SLAVE_ERR_EN
            .o_TX_Underrun (und[g]),
            .o_RX_Overrun  (ovr[g]),
`endif
            .o_SPI_MISO_OE (oe[g])
        );
    end

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every RX pulse with its cycle stamp.
    always @(negedge clk) begin
        for (int g = 0; g < 4; g++) begin
            if (rx_dv[g] === 1'b1) begin
                rx_ev_t e;
                e.m   = g;
                e.c   = cyc;
                e.dat = rx_byte[g];
                rxq.push_back(e);
            end
`ifdef SPI_SLAVE_ERR_EN
            if (und[g] === 1'b1) und_cnt[g] = und_cnt[g] + 1;
`endif
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_tx(input int m, input logic [7:0] b);
        tx_byte  = b;
        tx_dv[m] = 1'b1;
        @(negedge clk);
        tx_dv[m] = 1'b0;
    endtask

    // Half SCK period (4 clocks), optionally carrying a holding-register write.
    task automatic half(input int m, input bit wr, input logic [7:0] wb);
        if (wr) begin
            chk("ready_before_refill", {31'd0, tx_rdy[m]}, 32'd1);
            write_tx(m, wb);
            cyc_wait(3);
        end else begin
            cyc_wait(4);
        end
    endtask

    // Master side of nbits bits, MSb first; MISO captured just before each master sample edge.
    task automatic send_bits(input int m, input logic [7:0] b, input int nbits,
                             input bit wr, input logic [7:0] wb, output logic [7:0] got);
        logic cpol;
        bit   cpha;
        cpol = (m >= 2);
        cpha = (m % 2 == 1);
        got  = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (!cpha) begin
                mosi[m] = b[i];
                half(m, wr && (i == 3), wb);
                got[i] = miso[m];
                sck[m] = ~cpol;
                if (i == 0) smp_q.push_back(cyc);
                cyc_wait(4);
                sck[m] = cpol;
            end else begin
                sck[m]  = ~cpol;
                mosi[m] = b[i];
                half(m, wr && (i == 3), wb);
                got[i] = miso[m];
                sck[m] = cpol;
                if (i == 0) smp_q.push_back(cyc);
                cyc_wait(4);
            end
        end
    endtask

    // Full transfer described by tb_* with model-derived expectations.
    task automatic xfer(input int m);
        logic [7:0] got;
        logic [7:0] exp_miso;
        int         base;
        base = rxq.size();
        smp_q.delete();
        if (tb_pre_en) begin
            chk("ready_idle", {31'd0, tx_rdy[m]}, 32'd1);
            write_tx(m, tb_pre);
            chk("ready_after_dv", {31'd0, tx_rdy[m]}, 32'd0);
            write_tx(m, ~tb_pre);   // refused: register already full
        end
        cs_n[m] = 1'b0;
        cyc_wait(8);
        chk("busy_active", {31'd0, busy[m]}, 32'd1);
        chk("oe_active", {31'd0, oe[m]}, 32'd1);
        chk("ready_after_entry", {31'd0, tx_rdy[m]}, 32'd1);
        exp_miso = tb_pre_en ? tb_pre : 8'h00;
        for (int k = 0; k < tb_n; k++) begin
            send_bits(m, tb_b[k], 8, tb_rf_en[k], tb_rf[k], got);
            chk($sformatf("miso_m%0d_b%0d", m, k), {24'd0, got}, {24'd0, exp_miso});
            exp_miso = tb_rf_en[k] ? tb_rf[k] : 8'h00;
        end
        cyc_wait(4);
        cs_n[m] = 1'b1;
        cyc_wait(12);
        chk("rx_dv_count", rxq.size() - base, tb_n);
        for (int k = 0; k < tb_n; k++) begin
            if (base + k < rxq.size()) begin
                chk("rx_mode", rxq[base+k].m, m);
                chk($sformatf("rx_m%0d_b%0d", m, k), {24'd0, rxq[base+k].dat}, {24'd0, tb_b[k]});
                chk("rx_latency", rxq[base+k].c, smp_q[k] + 1 + SYNC + 2);
            end
        end
        chk("rx_byte_port", {24'd0, rx_byte[m]}, {24'd0, tb_b[tb_n-1]});
        chk("busy_idle", {31'd0, busy[m]}, 32'd0);
        chk("oe_idle", {31'd0, oe[m]}, 32'd0);
        chk("ready_end", {31'd0, tx_rdy[m]}, 32'd1);
    endtask

    task automatic chk_reset(input int m);
        chk("rst_ready", {31'd0, tx_rdy[m]}, 32'd1);
        chk("rst_rx_dv", {31'd0, rx_dv[m]}, 32'd0);
        chk("rst_rx_byte", {24'd0, rx_byte[m]}, 32'd0);
        chk("rst_busy", {31'd0, busy[m]}, 32'd0);
        chk("rst_miso", {31'd0, miso[m]}, 32'd0);
        chk("rst_oe", {31'd0, oe[m]}, 32'd0);
    endtask

    task automatic set1(input bit pe, input logic [7:0] p, input logic [7:0] b0);
        tb_n      = 1;
        tb_pre_en = pe;
        tb_pre    = p;
        tb_b[0]   = b0;
        for (int k = 0; k < 3; k++) tb_rf_en[k] = 1'b0;
    endtask

    initial begin
        logic [7:0] got;
        int         base;
`ifdef SPI_SLAVE_ERR_EN
        int         ubase;
`endif
        for (int g = 0; g < 4; g++) begin
            tx_dv[g] = 1'b0;
            sck[g]   = (g >= 2);
            cs_n[g]  = 1'b1;
            mosi[g]  = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
            tb_b[k] = 8'h00; tb_rf[k] = 8'h00; tb_rf_en[k] = 1'b0;
        end
        cyc_wait(3);
        rst = 1'b0;
        cyc_wait(4);
        for (int g = 0; g < 4; g++) chk_reset(g);

        // Mode 0: preload A5, master sends 3C
        set1(1'b1, 8'hA5, 8'h3C);
        xfer(0);

        // Modes 1..3: preload 7E, master sends 81
        for (int m = 1; m < 4; m++) begin
            set1(1'b1, 8'h7E, 8'h81);
            xfer(m);
        end

        // Two bytes in one CS low, every mode
        for (int m = 0; m < 4; m++) begin
            set1(1'b1, 8'h11, 8'hDE);
            tb_n = 2; tb_b[1] = 8'hAD;
            tb_rf_en[0] = 1'b1; tb_rf[0] = 8'h22;
            xfer(m);
        end

        // No preload: MISO all zero
`ifdef SPI_SLAVE_ERR_EN
        ubase = und_cnt[0];
`endif
        set1(1'b0, 8'h00, 8'hFF);
        xfer(0);
`ifdef SPI_SLAVE_ERR_EN
        chk("underrun_pulses", und_cnt[0] - ubase, 1);
`endif

        // Abort after 5 SCK periods, then a clean 5A (modes 0 and 3)
        for (int m = 0; m < 4; m += 3) begin
            base = rxq.size();
            cs_n[m] = 1'b0;
            cyc_wait(8);
            send_bits(m, 8'hF0, 5, 1'b0, 8'h00, got);
            cs_n[m] = 1'b1;
            cyc_wait(12);
            chk("abort_no_dv", rxq.size() - base, 0);
            chk("abort_oe", {31'd0, oe[m]}, 32'd0);
            set1(1'b0, 8'h00, 8'h5A);
            xfer(m);
        end

        // Reset pulse mid-byte with the holding register full
        base = rxq.size();
        cs_n[0] = 1'b0;
        cyc_wait(8);
        send_bits(0, 8'hC3, 3, 1'b0, 8'h00, got);
        write_tx(0, 8'h99);
        chk("ready_full_pre_rst", {31'd0, tx_rdy[0]}, 32'd0);
        send_bits(0, 8'hC3, 2, 1'b0, 8'h00, got);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset(0);
        cs_n[0] = 1'b1;
        cyc_wait(12);
        chk("rst_no_dv", rxq.size() - base, 0);
        set1(1'b1, 8'h42, 8'h24);
        xfer(0);

        // Randomized transfers
        for (int it = 0; it < 12; it++) begin
            int m;
            m         = int'($urandom_range(0, 3));
            tb_n      = int'($urandom_range(1, 3));
            tb_pre_en = 1'($urandom_range(0, 1));
            tb_pre    = 8'($urandom);
            for (int k = 0; k < 3; k++) begin
                tb_b[k]     = 8'($urandom);
                tb_rf_en[k] = 1'($urandom_range(0, 1));
                tb_rf[k]    = 8'($urandom);
            end
            xfer(m);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder: the other end of the team's SPI master.
- Oversamples the external SCK, CS_n and MOSI pins on the system clock.
- Shifts bytes in from MOSI and out on MISO, MSb first.
- Presents received bytes and accepts transmit bytes through the same DV/Ready byte handshake the SPI master uses. Used for the ADS1292 device model and the board loopback bench.

Parameters:
- SPI_MODE, 0, CPOL/CPHA select 0..3 (CPOL = mode 2|3, CPHA = mode 1|3).
- SYNC_STAGES, 2, flops in each pin synchronizer; must be >= 2.

Ports:
- i_Clk  in  1  system clock; must be >= 8x SCK frequency.
- i_Rst  in  1  synchronous, active-high reset.
- i_TX_Byte  in  8  next byte to send on MISO.
- i_TX_DV  in  1  one-cycle pulse; loads i_TX_Byte into the holding register.
- o_TX_Ready  out  1  holding register empty; may pulse i_TX_DV.
- o_RX_DV  out  1  one-cycle pulse; o_RX_Byte valid.
- o_RX_Byte  out  8  last complete received byte.
- o_Busy  out  1  synchronized CS_n is low.
- i_SPI_Clk  in  1  SCK from master, asynchronous.
- i_SPI_CS_n  in  1  chip select, active low, asynchronous.
- i_SPI_MOSI  in  1  master data, asynchronous.
- o_SPI_MISO  out  1  slave data.
- o_SPI_MISO_OE  out  1  MISO output enable; equals ~CS_n synchronized.

Behaviour:
- Reset values: o_TX_Ready=1, o_RX_DV=0, o_RX_Byte=0x00, o_Busy=0, o_SPI_MISO=0, o_SPI_MISO_OE=0.
- Reset clears the holding register, shift registers, and bit counter=7. The synchronizers reset to SCK=CPOL, CS_n=1, MOSI=0.
- Reset mid-transfer: abort immediately; no o_RX_DV is produced.
- Synchronization and edge detection:
  - SCK, CS_n and MOSI each pass through SYNC_STAGES flops.
  - A previous-value register on SCK_s yields one-cycle strobes:
    - lead: SCK_s leaves CPOL.
    - trail: SCK_s returns to CPOL.
  - Edges are ignored while CS_n_s=1.
- State machine:
  - IDLE -> ACTIVE on CS_n_s falling.
  - ACTIVE -> IDLE on CS_n_s rising.
  - On entry to ACTIVE: bit counter=7, and the TX shift register is loaded from the holding register, or 0x00 if it is empty.
  - CPHA=0: o_SPI_MISO = tx[7], driven in the cycle after the CS fall is detected.
- Sample and drive rules:
  - Sample point: lead if CPHA=0, trail if CPHA=1. rx[bit] <= MOSI_s, then bit counter decrements.
  - Drive point: trail if CPHA=0, lead if CPHA=1. o_SPI_MISO <= next tx bit.
- Byte boundary (sample with bit counter=0):
  - o_RX_Byte <= {rx[7:1],MOSI_s}.
  - o_RX_DV=1 for exactly one cycle.
  - Bit counter wraps to 7.
  - TX shift register reloads from the holding register (0x00 if empty), and the holding register is marked empty.
  - CPHA=0: the new tx[7] is driven at the next trail.
  - Back-to-back bytes within one CS low are supported without gaps.
- Handshake:
  - o_TX_Ready = holding register empty.
  - i_TX_DV while o_TX_Ready=0 is ignored.
  - i_TX_DV in the same cycle as a reload: the reload takes the old content, and the new byte is then written into the now-empty holding register.
  - o_TX_Ready deasserts the cycle after an accepted i_TX_DV.
- CS_n rises mid-byte:
  - Partial RX data is discarded; no o_RX_DV.
  - Bit counter returns to 7; o_SPI_MISO_OE=0.
  - The holding register is unaffected.
- Latency: o_RX_DV asserts SYNC_STAGES+2 i_Clk cycles after the first i_Clk edge that sees the final sampling SCK edge.

Optional Feature:
- Macro: SPI_SLAVE_ERR_EN.
- With the macro defined:
  - Adds ports o_TX_Underrun (out, 1) and o_RX_Overrun (out, 1), both one-cycle pulses, reset 0.
  - o_TX_Underrun pulses when a reload finds the holding register empty.
  - o_RX_Overrun pulses when o_RX_DV fires within 8 SCK sample points of the previous one.
- Without the macro: the ports are absent and underrun silently sends 0x00.

Test Plan:
- Mode 0, SCK = i_Clk/8:
  - Preload 0xA5, then the master sends 0x3C. Required: o_RX_Byte=0x3C with a single o_RX_DV pulse, MISO bits observed = 1010_0101, o_TX_Ready returns to 1.
- Modes 1, 2, 3: same exchange, with 0x81 sent and 0x7E preloaded. Required: correct capture in every mode, MISO stable at each master sample edge.
- Two bytes in one CS low:
  - Preload 0x11, reload 0x22 on o_TX_Ready. Master sends 0xDE, 0xAD.
  - Required: o_RX_DV twice (0xDE then 0xAD); MISO carries 0x11 then 0x22.
- No preload, master sends 0xFF: MISO all zero; o_TX_Underrun pulses once when SPI_SLAVE_ERR_EN is defined.
- Abort mid-byte: CS_n rises after 5 SCK periods. Required: no o_RX_DV, o_SPI_MISO_OE=0; the next full byte 0x5A is received correctly.
- i_Rst asserted for one cycle mid-byte: all outputs return to reset values on the next cycle; the next transfer starts clean.
